// File: rtl/manchester_rx_dec_pkg.sv
// Shared constants and the per-pair Manchester decode used by the receive-path decoder.
package manchester_pkg;

    localparam bit POL_IEEE   = 1'b0;
    localparam bit POL_THOMAS = 1'b1;
    localparam bit ERR_DROP   = 1'b0;
    localparam bit ERR_FLAG   = 1'b1;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic dbit;
        logic illegal;
    } pair_dec_t;

    // 00 and 11 carry no transition; they decode to 0 and raise the illegal flag.
    function automatic pair_dec_t mdec_pair(input logic lo, input logic hi, input logic pol);
        pair_dec_t r;
        r.illegal = ~(lo ^ hi);
        r.dbit    = r.illegal ? 1'b0 : (pol ? hi : lo);
        return r;
    endfunction

endpackage

// File: rtl/manchester_rx_dec_if.sv
// Chip-word input stream and decoded-word output stream of the Manchester decoder.
interface manchester_rx_dec_if #(
    parameter int DATA_W = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [2*DATA_W-1:0]   s_chips;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_data;
    logic                  m_err;

    modport slave (
        input  s_valid, s_chips, m_ready,
        output s_ready, m_valid, m_data, m_err
    );

    modport master (
        output s_valid, s_chips, m_ready,
        input  s_ready, m_valid, m_data, m_err
    );
endinterface

// File: rtl/manchester_rx_dec_fifo2.sv
// Two-entry output buffer holding {data, err}; head is always presented on dout.
module manchester_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W:0]   din,
    output logic [DATA_W:0]   dout,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);
    logic [DATA_W:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign count   = cnt_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the output reads zero while idle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/manchester_rx_dec.sv
// Streaming Manchester decoder: decode stage D, 2-entry output FIFO, registered s_ready
// and saturating word/error counters.
module manchester_rx_dec
    import manchester_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int POLARITY = int'(POL_IEEE),
    parameter int ERR_MODE = int'(ERR_DROP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    manchester_rx_dec_if.slave   bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam bit POL_SEL  = (POLARITY == int'(POL_THOMAS));
    localparam bit DROP_ERR = (ERR_MODE == int'(ERR_DROP));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    pair_dec_t         pd;

    logic [DATA_W-1:0] data_p0;
    logic              err_p0;
    logic              vld_p0;

    logic              rdy_q;
    logic              rdy_nxt;
    logic              in_xfer;
    logic              drop_p0;
    logic              d_leave;
    logic              push;
    logic              pop;
    logic              vld_nxt;
    logic [1:0]        occ_nxt;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;
    logic [DATA_W:0]   head_p1;

    always_comb begin
        dec_data = '0;
        dec_err  = 1'b0;
        pd       = '0;
        for (int k = 0; k < DATA_W; k++) begin
            pd          = mdec_pair(bus.s_chips[2*k], bus.s_chips[2*k+1], POL_SEL);
            dec_data[k] = pd.dbit;
            dec_err     = dec_err | pd.illegal;
        end
    end

    assign in_xfer = bus.s_valid & rdy_q;
    assign drop_p0 = DROP_ERR & err_p0;
    assign pop     = ~fifo_empty & bus.m_ready;
    // D empties when its word is dropped or the FIFO has (or is making) room.
    assign d_leave = vld_p0 & (drop_p0 | ~fifo_full | pop);
    assign push    = d_leave & ~drop_p0;
    assign vld_nxt = in_xfer | (vld_p0 & ~d_leave);
    assign occ_nxt = fifo_cnt + {1'b0, push} - {1'b0, pop};
    // Ready is registered, so keep one of the three slots free for the word it may admit.
    assign rdy_nxt = ({1'b0, occ_nxt} + {2'b00, vld_nxt}) <= 3'd2;

    // ---- stage D (p0): decoded word ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= vld_nxt;
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            data_p0 <= dec_data;
            err_p0  <= dec_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_q <= 1'b0;
        else
            rdy_q <= rdy_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (cnt_clr) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (in_xfer)
                word_cnt <= sat_inc(word_cnt);
            if (d_leave & err_p0)
                err_cnt <= sat_inc(err_cnt);
        end
    end

    // ---- output FIFO (p1) ----
    manchester_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({data_p0, err_p0}),
        .dout  (head_p1),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.s_ready = rdy_q;
    assign bus.m_valid = ~fifo_empty;
    assign bus.m_data  = head_p1[DATA_W:1];
    assign bus.m_err   = head_p1[0];
endmodule

// File: tb/tb_manchester_rx_dec.sv
// Directed bench for manchester_rx_dec: three parameter variants driven from one sequence.
module tb_manchester_rx_dec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_a, clr_b, clr_c;
    logic [15:0] wc_a, ec_a, wc_b, ec_b, wc_c, ec_c;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    manchester_rx_dec_if #(.DATA_W(8)) ifa ();
    manchester_rx_dec_if #(.DATA_W(8)) ifb ();
    manchester_rx_dec_if #(.DATA_W(8)) ifc ();

    manchester_rx_dec #(.DATA_W(8), .POLARITY(0), .ERR_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .cnt_clr(clr_a), .word_cnt(wc_a), .err_cnt(ec_a));
    manchester_rx_dec #(.DATA_W(8), .POLARITY(0), .ERR_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .cnt_clr(clr_b), .word_cnt(wc_b), .err_cnt(ec_b));
    manchester_rx_dec #(.DATA_W(8), .POLARITY(1), .ERR_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc), .cnt_clr(clr_c), .word_cnt(wc_c), .err_cnt(ec_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] bp_chips [4];
    logic [7:0]  bp_exp   [3];
    int          acc;
    int          cyc;
    logic        pre;

    initial begin
        bp_chips[0] = 16'h5555; bp_chips[1] = 16'hAAAA;
        bp_chips[2] = 16'h6666; bp_chips[3] = 16'h9999;
        bp_exp[0] = 8'hFF; bp_exp[1] = 8'h00; bp_exp[2] = 8'hAA;

        ifa.s_valid = 0; ifa.s_chips = '0; ifa.m_ready = 1;
        ifb.s_valid = 0; ifb.s_chips = '0; ifb.m_ready = 1;
        ifc.s_valid = 0; ifc.s_chips = '0; ifc.m_ready = 1;
        clr_a = 0; clr_b = 0; clr_c = 0;

        // reset state
        repeat (3) tick();
        chk("rst_s_ready", ifa.s_ready, 0);
        chk("rst_m_valid", ifa.m_valid, 0);
        chk("rst_m_data", ifa.m_data, 0);
        chk("rst_m_err", ifa.m_err, 0);
        chk("rst_word_cnt", wc_a, 0);
        chk("rst_err_cnt", ec_a, 0);
        rst_n = 1;
        tick();
        chk("first_clk_ready", ifa.s_ready, 1);

        // streaming, POLARITY=0
        ifa.s_valid = 1; ifa.s_chips = 16'h5555;
        tick();
        chk("lat_not_yet", ifa.m_valid, 0);
        ifa.s_chips = 16'hAAAA;
        tick();
        chk("s0_valid", ifa.m_valid, 1);
        chk("s0_data", ifa.m_data, 8'hFF);
        chk("s0_err", ifa.m_err, 0);
        ifa.s_chips = 16'h6666;
        tick();
        chk("s1_data", ifa.m_data, 8'h00);
        chk("s1_ready", ifa.s_ready, 1);
        ifa.s_valid = 0;
        tick();
        chk("s2_data", ifa.m_data, 8'hAA);
        chk("s2_err", ifa.m_err, 0);
        tick();
        chk("s_drained", ifa.m_valid, 0);
        chk("s_word_cnt", wc_a, 3);
        chk("s_err_cnt", ec_a, 0);

        // POLARITY=1
        ifc.s_valid = 1; ifc.s_chips = 16'h6666;
        tick();
        ifc.s_valid = 0;
        tick();
        chk("pol1_valid", ifc.m_valid, 1);
        chk("pol1_data", ifc.m_data, 8'h55);
        chk("pol1_wcnt", wc_c, 1);
        chk("pol1_ecnt", ec_c, 0);

        // ERR_MODE=0 drop
        clr_a = 1;
        tick();
        clr_a = 0;
        chk("clr_word_cnt", wc_a, 0);
        ifa.s_valid = 1; ifa.s_chips = 16'h5554;
        tick();
        ifa.s_chips = 16'h5555;
        tick();
        chk("drop_no_out", ifa.m_valid, 0);
        ifa.s_valid = 0;
        tick();
        chk("drop_good_valid", ifa.m_valid, 1);
        chk("drop_good_data", ifa.m_data, 8'hFF);
        chk("drop_good_err", ifa.m_err, 0);
        tick();
        chk("drop_only_one", ifa.m_valid, 0);
        chk("drop_err_cnt", ec_a, 1);
        chk("drop_word_cnt", wc_a, 2);

        // ERR_MODE=1 flag
        ifb.s_valid = 1; ifb.s_chips = 16'h5557;
        tick();
        ifb.s_valid = 0;
        tick();
        chk("flag_valid", ifb.m_valid, 1);
        chk("flag_data", ifb.m_data, 8'hFE);
        chk("flag_err", ifb.m_err, 1);
        chk("flag_err_cnt", ec_b, 1);
        chk("flag_word_cnt", wc_b, 1);

        // backpressure
        ifa.m_ready = 0; ifa.s_valid = 1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            ifa.s_chips = bp_chips[acc];
            pre = ifa.s_ready;
            tick();
            if (pre) acc++;
        end
        ifa.s_valid = 0;
        chk("bp_accepts", acc, 3);
        chk("bp_ready_low", ifa.s_ready, 0);
        chk("bp_head_valid", ifa.m_valid, 1);
        chk("bp_head_stable", ifa.m_data, 8'hFF);
        ifa.m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", ifa.m_valid, 1);
            chk("bp_out_data", ifa.m_data, bp_exp[i]);
            tick();
        end
        chk("bp_no_dup", ifa.m_valid, 0);
        chk("bp_word_cnt", wc_a, 5);

        // cnt_clr during an accept
        ifa.s_valid = 1; ifa.s_chips = 16'h5555; clr_a = 1;
        pre = ifa.s_ready;
        tick();
        chk("clr_accept_seen", pre, 1);
        chk("clr_pri_word", wc_a, 0);
        chk("clr_pri_err", ec_a, 0);
        ifa.s_valid = 0; clr_a = 0;
        repeat (3) tick();

        // async reset with FIFO full
        ifa.m_ready = 0; ifa.s_valid = 1; ifa.s_chips = 16'hAAAA;
        repeat (5) tick();
        ifa.s_valid = 0;
        chk("full_valid", ifa.m_valid, 1);
        chk("full_ready", ifa.s_ready, 0);
        #3;
        rst_n = 0;
        #1;
        chk("arst_m_valid", ifa.m_valid, 0);
        chk("arst_s_ready", ifa.s_ready, 0);
        chk("arst_word_cnt", wc_a, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        chk("arst_empty_after", ifa.m_valid, 0);

        // word_cnt saturation
        ifa.m_ready = 1; ifa.s_valid = 1; ifa.s_chips = 16'h5555;
        acc = 0; cyc = 0;
        while (acc < 65535 && cyc < 70000) begin
            pre = ifa.s_ready;
            tick();
            if (pre) acc++;
            cyc++;
        end
        chk("sat_accepts", acc, 65535);
        chk("sat_reach", wc_a, 16'hFFFF);
        repeat (3) tick();
        chk("sat_hold_ready", ifa.s_ready, 1);
        chk("sat_hold", wc_a, 16'hFFFF);
        ifa.s_valid = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
